// File: rtl/tm_seq_pkg.sv
// Shared types and defaults for the TuringMachine step sequencer.
// TM_AUTORUN_EN selects the auto-run build (third button, AUTO state, timer).
package tm_seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AUTO   = 3'd1,
    PULSE  = 3'd2,
    SETTLE = 3'd3,
    HALTED = 3'd4
  } seq_state_t;

  // 10 ms settle window and 0.5 s auto-step spacing at 100 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
  localparam int unsigned AUTO_PERIOD_DEF     = 50_000_000;

  localparam int BTN_NEXT = 0;
  localparam int BTN_DONE = 1;
  localparam int BTN_RUN  = 2;
`ifdef TM_AUTORUN_EN
  localparam int NUM_BTN = 3;
`else
  localparam int NUM_BTN = 2;
`endif

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle registered pulse on each accepted rising level.
module btn_debounce
  import tm_seq_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk100,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronized level agrees restarts the count.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        press_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/tm_step_sequencer.sv
// Button front-end for the TuringMachine: clean Next/Done strobes, halt
// detection and (with TM_AUTORUN_EN defined) a timed auto-run mode.
module tm_step_sequencer
  import tm_seq_pkg::*;
#(
  parameter int                 STATE_W         = 4,
  parameter logic [STATE_W-1:0] HALT_STATE      = 4'hF,
  parameter int unsigned        DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned        AUTO_PERIOD     = AUTO_PERIOD_DEF,
  parameter int                 STEP_W          = 16
) (
  input  logic               clk100,
  input  logic               reset_n,
  input  logic               btn_next_raw,
  input  logic               btn_done_raw,
  input  logic               btn_run_raw,
  input  logic [STATE_W-1:0] tm_state,
  output logic               tm_next,
  output logic               tm_done,
  output logic               running,
  output logic               halted,
  output logic [STEP_W-1:0]  step_count,
  output logic [2:0]         seq_state
);

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] unused_btn_level;

`ifdef TM_AUTORUN_EN
  assign btn_raw = {btn_run_raw, btn_done_raw, btn_next_raw};
`else
  logic unused_run_raw;
  localparam int unsigned unused_auto_period = AUTO_PERIOD;
  assign btn_raw        = {btn_done_raw, btn_next_raw};
  assign unused_run_raw = btn_run_raw;
`endif

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk100 (clk100),
      .reset_n(reset_n),
      .raw    (btn_raw[i]),
      .level  (unused_btn_level[i]),
      .press  (btn_press[i])
    );
  end

  logic ev_next, ev_done;
  assign ev_next = btn_press[BTN_NEXT];
  assign ev_done = btn_press[BTN_DONE];

`ifdef TM_AUTORUN_EN
  localparam int TMR_W = $clog2(AUTO_PERIOD);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(AUTO_PERIOD - 1);

  logic             ev_run;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             running_q, running_d;
  assign ev_run = btn_press[BTN_RUN];
`endif

  seq_state_t        state_q, state_d;
  logic              tm_next_q, tm_next_d;
  logic              tm_done_q, tm_done_d;
  logic              halted_q, halted_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] step_inc;

  assign step_inc = (step_q == {STEP_W{1'b1}}) ? step_q : step_q + STEP_W'(1);

  // Strobes are computed for the state being entered, so they are high
  // for exactly the cycle spent in PULSE (tm_next) or after a done.
  always_comb begin
    state_d   = state_q;
    tm_next_d = 1'b0;
    tm_done_d = 1'b0;
    halted_d  = halted_q;
    step_d    = step_q;
`ifdef TM_AUTORUN_EN
    timer_d   = timer_q;
    running_d = running_q;
`endif
    case (state_q)
      IDLE: begin
        if (ev_done) begin
          tm_done_d = 1'b1;
          step_d    = '0;
        end
`ifdef TM_AUTORUN_EN
        else if (ev_run) begin
          state_d   = AUTO;
          running_d = 1'b1;
          timer_d   = '0;
        end
`endif
        else if (ev_next) begin
          state_d   = PULSE;
          tm_next_d = 1'b1;
          step_d    = step_inc;
        end
      end
      AUTO: begin
`ifdef TM_AUTORUN_EN
        if (ev_run) begin
          state_d   = IDLE;
          running_d = 1'b0;
          timer_d   = '0;
        end else if (timer_q == TMR_LAST) begin
          state_d   = PULSE;
          tm_next_d = 1'b1;
          step_d    = step_inc;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
`else
        state_d = IDLE;
`endif
      end
      PULSE: state_d = SETTLE;
      SETTLE: begin
        if (tm_state == HALT_STATE) begin
          state_d  = HALTED;
          halted_d = 1'b1;
`ifdef TM_AUTORUN_EN
          running_d = 1'b0;
`endif
        end
`ifdef TM_AUTORUN_EN
        else if (running_q) begin
          state_d = AUTO;
          timer_d = '0;
        end
`endif
        else begin
          state_d = IDLE;
        end
      end
      HALTED: begin
        if (ev_done) begin
          state_d   = IDLE;
          tm_done_d = 1'b1;
          halted_d  = 1'b0;
          step_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      tm_next_q <= 1'b0;
      tm_done_q <= 1'b0;
      halted_q  <= 1'b0;
      step_q    <= '0;
`ifdef TM_AUTORUN_EN
      timer_q   <= '0;
      running_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tm_next_q <= tm_next_d;
      tm_done_q <= tm_done_d;
      halted_q  <= halted_d;
      step_q    <= step_d;
`ifdef TM_AUTORUN_EN
      timer_q   <= timer_d;
      running_q <= running_d;
`endif
    end
  end

  assign tm_next    = tm_next_q;
  assign tm_done    = tm_done_q;
  assign halted     = halted_q;
  assign step_count = step_q;
  assign seq_state  = state_q;
`ifdef TM_AUTORUN_EN
  assign running = running_q;
`else
  assign running = 1'b0;
`endif

endmodule

// File: tb/tb_tm_step_sequencer.sv
// Self-checking bench for tm_step_sequencer: directed steps plus random
// button traffic, every cycle compared against a behavioural model.
module tb_tm_step_sequencer;

  localparam int D = 4;
  localparam int P = 8;
`ifdef TM_AUTORUN_EN
  localparam bit AUTOEN = 1'b1;
`else
  localparam bit AUTOEN = 1'b0;
`endif

  logic        clk100 = 1'b0;
  logic        reset_n;
  logic        btn_next_raw, btn_done_raw, btn_run_raw;
  logic [3:0]  tm_state;
  logic        tm_next, tm_done, running, halted;
  logic [15:0] step_count;
  logic [2:0]  seq_state;

  tm_step_sequencer #(
    .STATE_W(4), .HALT_STATE(4'hF), .DEBOUNCE_CYCLES(D),
    .AUTO_PERIOD(P), .STEP_W(16)
  ) dut (
    .clk100(clk100), .reset_n(reset_n),
    .btn_next_raw(btn_next_raw), .btn_done_raw(btn_done_raw),
    .btn_run_raw(btn_run_raw), .tm_state(tm_state),
    .tm_next(tm_next), .tm_done(tm_done), .running(running),
    .halted(halted), .step_count(step_count), .seq_state(seq_state)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_next = 0;
  int n_done = 0;
  int last_next = -1;
  int gaps[$];

  // Reference model. Buttons: raw samples delayed two edges, accepted when
  // the last D delayed samples all disagree with the accepted level; the
  // resulting press is acted upon one edge later.
  bit          sq[3][$];
  bit          win[3][$];
  bit          lvl[3];
  bit          pend[3];
  int          ph;      // 0 idle, 1 auto, 2 pulse, 3 settle, 4 halted
  int          left;    // edges remaining until the next auto step
  bit          m_run, m_halt, e_next, e_done;
  logic [15:0] m_steps;

  task automatic model_edge();
    bit ev[3];
    bit raw[3];
    bit sv, all_diff;
    raw[0] = btn_next_raw; raw[1] = btn_done_raw; raw[2] = btn_run_raw;
    e_next = 1'b0;
    e_done = 1'b0;
    if (!reset_n) begin
      for (int b = 0; b < 3; b++) begin
        sq[b].delete(); sq[b].push_back(1'b0); sq[b].push_back(1'b0);
        win[b].delete(); lvl[b] = 1'b0; pend[b] = 1'b0;
      end
      ph = 0; left = 0; m_run = 0; m_halt = 0; m_steps = '0;
      return;
    end
    ev = pend;
    if (!AUTOEN) ev[2] = 1'b0;
    for (int b = 0; b < 3; b++) begin
      sv = sq[b].pop_front();
      sq[b].push_back(raw[b]);
      pend[b] = 1'b0;
      win[b].push_back(sv);
      if (win[b].size() > D) void'(win[b].pop_front());
      all_diff = (win[b].size() == D);
      for (int k = 0; k < win[b].size(); k++)
        if (win[b][k] == lvl[b]) all_diff = 1'b0;
      if (all_diff) begin
        lvl[b] = !lvl[b];
        pend[b] = lvl[b];
        win[b].delete();
      end
    end
    case (ph)
      0: if (ev[1]) begin e_done = 1; m_steps = '0; end
         else if (ev[2]) begin ph = 1; m_run = 1; left = P; end
         else if (ev[0]) begin
           ph = 2; e_next = 1;
           if (m_steps != 16'hFFFF) m_steps = m_steps + 16'd1;
         end
      1: if (ev[2]) begin ph = 0; m_run = 0; end
         else begin
           left = left - 1;
           if (left == 0) begin
             ph = 2; e_next = 1;
             if (m_steps != 16'hFFFF) m_steps = m_steps + 16'd1;
           end
         end
      2: ph = 3;
      3: if (tm_state == 4'hF) begin ph = 4; m_halt = 1; m_run = 0; end
         else if (m_run) begin ph = 1; left = P; end
         else ph = 0;
      default: if (ev[1]) begin ph = 0; e_done = 1; m_halt = 0; m_steps = '0; end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk100);
    #1;
    cyc++;
    chk("tm_next",    32'(tm_next),    32'(e_next));
    chk("tm_done",    32'(tm_done),    32'(e_done));
    chk("running",    32'(running),    32'(m_run));
    chk("halted",     32'(halted),     32'(m_halt));
    chk("step_count", 32'(step_count), 32'(m_steps));
    chk("seq_state",  32'(seq_state),  32'(ph));
    if (tm_next === 1'b1 && tm_done === 1'b1) chk("exclusive", 32'(tm_done), 32'd0);
    if (tm_next === 1'b1) begin
      n_next++;
      if (last_next >= 0) gaps.push_back(cyc - last_next);
      last_next = cyc;
    end
    if (tm_done === 1'b1) n_done++;
  endtask

  // Hold one raw button high for 'hold' cycles, then low long enough to settle.
  task automatic press(input int idx, input int hold);
    if (idx == 0) btn_next_raw = 1'b1;
    else if (idx == 1) btn_done_raw = 1'b1;
    else btn_run_raw = 1'b1;
    repeat (hold) tick();
    btn_next_raw = 1'b0; btn_done_raw = 1'b0; btn_run_raw = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    reset_n = 1'b0;
    btn_next_raw = 1'b1; btn_done_raw = 1'b1; btn_run_raw = 1'b1;
    tm_state = 4'h3;

    // 1: reset with buttons held, then a held Next yields one step
    repeat (3) tick();
    chk("t1_rst_seq", 32'(seq_state), 32'd0);
    reset_n = 1'b1; btn_done_raw = 1'b0; btn_run_raw = 1'b0;
    n_next = 0;
    repeat (9) tick();
    chk("t1_one_next", n_next, 1);
    btn_next_raw = 1'b0;
    repeat (12) tick();
    chk("t1_steps", 32'(step_count), 32'd1);

    // 2: short glitch ignored; proper presses count up
    n_next = 0;
    btn_next_raw = 1'b1; repeat (2) tick(); btn_next_raw = 1'b0; repeat (8) tick();
    chk("t2_glitch", n_next, 0);
    press(0, 10);
    chk("t2_one_next", n_next, 1);
    chk("t2_steps2", 32'(step_count), 32'd2);
    press(0, 10);
    chk("t2_steps3", 32'(step_count), 32'd3);

    // 3: halt, Next ignored, Done acknowledges
    tm_state = 4'hF;
    press(0, 8);
    chk("t3_halted", 32'(halted), 32'd1);
    chk("t3_seq4", 32'(seq_state), 32'd4);
    n_next = 0; n_done = 0;
    press(0, 8);
    chk("t3_next_ignored", n_next, 0);
    press(1, 8);
    chk("t3_one_done", n_done, 1);
    chk("t3_unhalt", 32'(halted), 32'd0);
    chk("t3_steps0", 32'(step_count), 32'd0);
    chk("t3_seq0", 32'(seq_state), 32'd0);
    tm_state = 4'h3;

`ifdef TM_AUTORUN_EN
    // 4: auto-run spacing and stop
    n_next = 0; last_next = -1; gaps.delete();
    btn_run_raw = 1'b1; repeat (6) tick(); btn_run_raw = 1'b0;
    chk("t4_running", 32'(running), 32'd1);
    for (int i = 0; i < 200 && n_next < 5; i++) tick();
    chk("t4_five_steps", n_next, 5);
    chk("t4_steps5", 32'(step_count), 32'd5);
    foreach (gaps[g]) chk("t4_gap", gaps[g], P + 2);
    press(2, 6);
    chk("t4_stopped", 32'(running), 32'd0);
    n_next = 0;
    repeat (30) tick();
    chk("t4_no_more", n_next, 0);
`endif

    // 5: run and done together in IDLE -> done only
    n_next = 0; n_done = 0;
    btn_run_raw = 1'b1; btn_done_raw = 1'b1;
    repeat (6) tick();
    btn_run_raw = 1'b0; btn_done_raw = 1'b0;
    repeat (20) tick();
    chk("t5_done", n_done, 1);
    chk("t5_no_run", 32'(running), 32'd0);
    chk("t5_no_next", n_next, 0);

    // 6: reset just before the auto terminal / run ignored without auto-run
    n_next = 0;
`ifdef TM_AUTORUN_EN
    btn_run_raw = 1'b1; repeat (6) tick(); btn_run_raw = 1'b0;
    for (int i = 0; i < 50 && !(ph == 1 && left == 2); i++) tick();
    chk("t6_in_auto", 32'(running), 32'd1);
    n_next = 0;
    reset_n = 1'b0; tick();
    chk("t6_rst_running", 32'(running), 32'd0);
    chk("t6_rst_seq", 32'(seq_state), 32'd0);
    reset_n = 1'b1;
    repeat (20) tick();
    chk("t6_no_next", n_next, 0);
`else
    press(2, 8);
    repeat (20) tick();
    chk("t6_run_ignored", 32'(running), 32'd0);
    chk("t6_no_next", n_next, 0);
`endif

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 5) == 0) btn_next_raw = ~btn_next_raw;
      if ($urandom_range(0, 7) == 0) btn_done_raw = ~btn_done_raw;
      if ($urandom_range(0, 9) == 0) btn_run_raw  = ~btn_run_raw;
      tm_state = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      reset_n = ($urandom_range(0, 299) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
